// File: rtl/pwm_duty_sequencer.sv
// Step prescaler and triangle "breathing" duty generator feeding the N-bit PWM stage.
// Duty ramps up to duty_max, holds, ramps down to duty_min, holds, and repeats.
module pwm_duty_sequencer #(
    parameter int N            = 8,
    parameter int CLK_DIV      = 100,
    parameter int UPDATE_STEPS = 256,
    parameter int DUTY_STEP    = 1,
    parameter int HOLD_UPDATES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] duty_min,
    input  logic [N-1:0] duty_max,
    output logic         step,
    output logic [N-1:0] duty,
    output logic [1:0]   phase,
    output logic         cycle_done
);

    typedef enum logic [1:0] {
        RISE    = 2'd0,
        HOLD_HI = 2'd1,
        FALL    = 2'd2,
        HOLD_LO = 2'd3
    } state_t;

    localparam int DW = $clog2(CLK_DIV);
    localparam int SW = (UPDATE_STEPS > 1) ? $clog2(UPDATE_STEPS) : 1;
    localparam int HW = (HOLD_UPDATES > 1) ? $clog2(HOLD_UPDATES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(UPDATE_STEPS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_UPDATES - 1);
    localparam logic [N:0]    DSTEP     = (N+1)'(DUTY_STEP);

    logic [DW-1:0] div_cnt_r,  div_nxt_s;
    logic [SW-1:0] step_cnt_r, step_nxt_s;
    logic [HW-1:0] hold_cnt_r, hold_nxt_s;
    state_t        state_r,    state_nxt_s;
    logic [N-1:0]  duty_r,     duty_nxt_s;
    logic          step_r;
    logic          cycle_done_r, done_nxt_s;
    logic          wrap_s, upd_s;
    logic [N:0]    sum_up_s, floor_s;

    // Prescaler wrap and duty-update tick qualifiers
    always_comb begin
        wrap_s = ena && (div_cnt_r == DIV_LAST);
        upd_s  = wrap_s && (step_cnt_r == STEP_LAST);
    end

    // Next values for the clock prescaler and step counter
    always_comb begin
        div_nxt_s  = div_cnt_r;
        step_nxt_s = step_cnt_r;
        if (ena) begin
            if (wrap_s) begin
                div_nxt_s = {DW{1'b0}};
            end else begin
                div_nxt_s = div_cnt_r + DW'(1);
            end
        end else begin
            div_nxt_s = div_cnt_r;
        end
        if (wrap_s) begin
            if (step_cnt_r == STEP_LAST) begin
                step_nxt_s = {SW{1'b0}};
            end else begin
                step_nxt_s = step_cnt_r + SW'(1);
            end
        end else begin
            step_nxt_s = step_cnt_r;
        end
    end

    // Ramp FSM next-state; limits compared one bit wider so nothing wraps
    always_comb begin
        state_nxt_s = state_r;
        duty_nxt_s  = duty_r;
        hold_nxt_s  = hold_cnt_r;
        done_nxt_s  = 1'b0;
        sum_up_s    = {1'b0, duty_r} + DSTEP;
        floor_s     = {1'b0, duty_min} + DSTEP;
        if (upd_s) begin
            case (state_r)
                RISE: begin
                    if (sum_up_s >= {1'b0, duty_max}) begin
                        duty_nxt_s  = duty_max;
                        state_nxt_s = HOLD_HI;
                        hold_nxt_s  = {HW{1'b0}};
                    end else begin
                        duty_nxt_s = sum_up_s[N-1:0];
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s = FALL;
                    end else begin
                        hold_nxt_s = hold_cnt_r + HW'(1);
                    end
                end
                FALL: begin
                    if ({1'b0, duty_r} <= floor_s) begin
                        duty_nxt_s  = duty_min;
                        state_nxt_s = HOLD_LO;
                        hold_nxt_s  = {HW{1'b0}};
                    end else begin
                        duty_nxt_s = duty_r - DSTEP[N-1:0];
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_nxt_s = RISE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        hold_nxt_s = hold_cnt_r + HW'(1);
                    end
                end
                default: begin
                    state_nxt_s = RISE;
                    hold_nxt_s  = {HW{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            duty_nxt_s  = duty_r;
            hold_nxt_s  = hold_cnt_r;
        end
    end

    // State, counter and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r    <= {DW{1'b0}};
            step_cnt_r   <= {SW{1'b0}};
            hold_cnt_r   <= {HW{1'b0}};
            state_r      <= RISE;
            duty_r       <= {N{1'b0}};
            step_r       <= 1'b0;
            cycle_done_r <= 1'b0;
        end else begin
            div_cnt_r    <= div_nxt_s;
            step_cnt_r   <= step_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            state_r      <= state_nxt_s;
            duty_r       <= duty_nxt_s;
            step_r       <= wrap_s;
            cycle_done_r <= done_nxt_s;
        end
    end

    assign step       = step_r;
    assign duty       = duty_r;
    assign phase      = state_r;
    assign cycle_done = cycle_done_r;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: a small N=4 instance for timing/profile/limits
// and an N=8, DUTY_STEP=200 instance for saturation, sharing clk/rst/ena.
module tb_pwm_duty_sequencer;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] duty_min_a, duty_max_a;
    logic       step_a, done_a;
    logic [3:0] duty_a;
    logic [1:0] phase_a;
    logic [7:0] duty_min_b, duty_max_b;
    logic       step_b, done_b;
    logic [7:0] duty_b;
    logic [1:0] phase_b;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_duty_sequencer #(
        .N(4), .CLK_DIV(3), .UPDATE_STEPS(2), .DUTY_STEP(4), .HOLD_UPDATES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .ena(ena),
        .duty_min(duty_min_a), .duty_max(duty_max_a),
        .step(step_a), .duty(duty_a), .phase(phase_a), .cycle_done(done_a)
    );

    pwm_duty_sequencer #(
        .N(8), .CLK_DIV(3), .UPDATE_STEPS(2), .DUTY_STEP(200), .HOLD_UPDATES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .ena(ena),
        .duty_min(duty_min_b), .duty_max(duty_max_b),
        .step(step_b), .duty(duty_b), .phase(phase_b), .cycle_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] duty_a;
        logic [1:0] phase_a;
        logic       done_a;
        logic [7:0] duty_b;
        logic [1:0] phase_b;
    } upd_vec_t;

    upd_vec_t prof[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int prev_duty;

        // Expected state after each update edge (every 6 clocks from release)
        prof[0]  = '{4'd4,  2'd0, 1'b0, 8'd200, 2'd0};
        prof[1]  = '{4'd8,  2'd0, 1'b0, 8'd255, 2'd1};
        prof[2]  = '{4'd12, 2'd0, 1'b0, 8'd255, 2'd1};
        prof[3]  = '{4'd15, 2'd1, 1'b0, 8'd255, 2'd2};
        prof[4]  = '{4'd15, 2'd1, 1'b0, 8'd55,  2'd2};
        prof[5]  = '{4'd15, 2'd2, 1'b0, 8'd0,   2'd3};
        prof[6]  = '{4'd11, 2'd2, 1'b0, 8'd0,   2'd3};
        prof[7]  = '{4'd7,  2'd2, 1'b0, 8'd0,   2'd0};
        prof[8]  = '{4'd3,  2'd2, 1'b0, 8'd200, 2'd0};
        prof[9]  = '{4'd0,  2'd3, 1'b0, 8'd255, 2'd1};
        prof[10] = '{4'd0,  2'd3, 1'b0, 8'd255, 2'd1};
        prof[11] = '{4'd0,  2'd0, 1'b1, 8'd255, 2'd2};

        rst = 1'b1;
        ena = 1'b0;
        duty_min_a = 4'd0;
        duty_max_a = 4'd15;
        duty_min_b = 8'd0;
        duty_max_b = 8'd255;

        repeat (2) tick();
        chk("reset duty",  duty_a,  0);
        chk("reset phase", phase_a, 0);
        chk("reset step",  step_a,  0);
        chk("reset done",  done_a,  0);
        chk("reset duty_b", duty_b, 0);
        rst = 1'b0;
        ena = 1'b1;

        // Prescaler timing and one full profile (72 clocks)
        prev_duty = 0;
        for (int k = 0; k < 12; k++) begin
            for (int c = 1; c <= 6; c++) begin
                tick();
                chk("step timing", step_a, int'(c % 3 == 0));
                chk("cycle_done", done_a, int'(c == 6 && prof[k].done_a));
                if (c == 3) begin
                    chk("duty between updates", duty_a, prev_duty);
                end else if (c == 6) begin
                    chk("profile duty",  duty_a,  prof[k].duty_a);
                    chk("profile phase", phase_a, prof[k].phase_a);
                    chk("sat duty_b",    duty_b,  prof[k].duty_b);
                    chk("sat phase_b",   phase_b, prof[k].phase_b);
                    chk("step_b",        step_b,  1);
                end else begin
                    chk("duty stable", duty_a, prev_duty);
                end
            end
            prev_duty = prof[k].duty_a;
        end

        // Second lap up to FALL at duty=7, then freeze with ena low
        repeat (48) tick();
        chk("pre-freeze duty",  duty_a,  7);
        chk("pre-freeze phase", phase_a, 2);
        ena = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("frozen step",  step_a,  0);
            chk("frozen duty",  duty_a,  7);
            chk("frozen phase", phase_a, 2);
        end
        ena = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("resume duty", duty_a, (c == 6) ? 3 : 7);
            chk("resume step", step_a, int'(c == 3 || c == 6));
        end

        // Walk into HOLD_HI, then a one-cycle reset
        repeat (42) tick();
        chk("hold_hi phase", phase_a, 1);
        chk("hold_hi duty",  duty_a,  15);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post-rst duty",  duty_a,  0);
        chk("post-rst phase", phase_a, 0);
        chk("post-rst step",  step_a,  0);
        chk("post-rst done",  done_a,  0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("post-rst first step", step_a, int'(c == 3));
        end

        // Lower duty_max below the ramp, then collapse the limits to 9
        repeat (9) tick();
        chk("ramp duty 8", duty_a, 8);
        duty_max_a = 4'd5;
        repeat (6) tick();
        chk("clamp duty_max",  duty_a,  5);
        chk("clamp phase",     phase_a, 1);
        duty_min_a = 4'd9;
        duty_max_a = 4'd9;
        repeat (18) tick();
        chk("clamp duty_min",  duty_a,  9);
        chk("clamp phase lo",  phase_a, 3);
        for (int u = 0; u < 8; u++) begin
            repeat (6) tick();
            chk("degenerate duty", duty_a, 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Upstream driver for the team's N-bit PWM stage. It generates the PWM `step` tick from a clock prescaler and produces a slowly ramping `duty` word as a triangle "breathing" profile: rise, hold high, fall, hold low, repeat. The `step` and `duty` outputs connect directly to the PWM block's `step` and `duty` inputs.

Parameters:
N, 8, width of the `duty` word (matches the PWM N).
CLK_DIV, 100, clock cycles per `step` pulse (>=2).
UPDATE_STEPS, 256, `step` pulses per duty update (>=1; 2^N gives one update per PWM period).
DUTY_STEP, 1, duty increment/decrement per update (1..2^N-1).
HOLD_UPDATES, 4, updates spent in each hold state (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ena  in  1  run enable; low freezes all counters, state and duty
duty_min  in  N  lower ramp limit
duty_max  in  N  upper ramp limit
step  out  1  one-cycle tick to the PWM `step` input
duty  out  N  duty word to the PWM `duty` input
phase  out  2  current state: 0=RISE, 1=HOLD_HI, 2=FALL, 3=HOLD_LO
cycle_done  out  1  one-cycle pulse on HOLD_LO->RISE

Behaviour:
- Reset (`rst` sampled high at posedge) puts the block in this state:
  - Internal: div_cnt=0, step_cnt=0, hold_cnt=0, state=RISE.
  - Outputs: `duty`=0, `step`=0, `cycle_done`=0.
  - `rst` has priority over everything, including mid-ramp and mid-hold.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Prescaler:
  - When `ena`=1, div_cnt counts 0..CLK_DIV-1 and wraps.
  - `step` is registered high for exactly one cycle when div_cnt==CLK_DIV-1. The first pulse appears CLK_DIV cycles after reset release with `ena` held high.
  - When `ena`=0, div_cnt holds, `step`=0, `cycle_done`=0, and state, duty and all counters hold.
- Update tick: upd = (`ena` & div_cnt==CLK_DIV-1 & step_cnt==UPDATE_STEPS-1).
  - step_cnt advances on each prescaler wrap and wraps at UPDATE_STEPS-1.
  - Duty and state change only on upd. The new value is visible the cycle after the upd edge, coincident with the corresponding `step` pulse.
- FSM, evaluated on upd. All comparisons use N+1-bit unsigned arithmetic, with no wrap.
  - RISE: if `duty`+DUTY_STEP >= `duty_max`, then `duty` <= `duty_max`, state -> HOLD_HI, hold_cnt <= 0. Otherwise `duty` += DUTY_STEP.
  - HOLD_HI: if hold_cnt==HOLD_UPDATES-1, state -> FALL. Otherwise hold_cnt++. `duty` unchanged.
  - FALL: if `duty` <= `duty_min`+DUTY_STEP, then `duty` <= `duty_min`, state -> HOLD_LO, hold_cnt <= 0. Otherwise `duty` -= DUTY_STEP.
  - HOLD_LO: if hold_cnt==HOLD_UPDATES-1, state -> RISE and `cycle_done` = 1 for one cycle. Otherwise hold_cnt++.
- Limit changes mid-operation:
  - `duty_max` lowered below the current `duty` during RISE: the next upd clamps `duty` to `duty_max` and enters HOLD_HI.
  - `duty_min` raised above the current `duty` during FALL: the next upd clamps `duty` up to `duty_min` and enters HOLD_LO.
- Degenerate limits (`duty_min` >= `duty_max`): RISE clamps to `duty_max` on its first upd and FALL clamps to `duty_min` on its first upd. The output alternates between the two limits and never wraps.
- `duty_max`=2^N-1 is legal. The N+1-bit sum prevents overflow, so full-on is reachable.

Test Plan:
1. Prescaler timing. Setup: N=4, CLK_DIV=3, UPDATE_STEPS=2, DUTY_STEP=4, HOLD_UPDATES=2, `duty_min`=0, `duty_max`=15, `rst` for 2 cycles then `ena`=1. Required: `step` high on cycles 3, 6, 9, … after release; `duty` updates every 6 cycles.
2. Full profile with the same setup. Required sequence of `duty` values:
   - 0, 4, 8, 12, 15 (`phase` 0→1)
   - 15 held for 2 updates
   - 11, 7, 3, 0 (`phase` 2→3)
   - 0 held for 2 updates, then `cycle_done` pulses once with `phase`=0.
   - One full cycle takes 72 clocks.
3. `ena` deasserted for 10 cycles mid-FALL at `duty`=7. Required: `step`=0 throughout, `duty`/`phase` frozen, and the sequence resumes 7→3 exactly one update after re-enable.
4. `rst` pulsed for 1 cycle in HOLD_HI. Required: next cycle `duty`=0, `phase`=0, `step`=0, and the first `step` arrives 3 cycles later.
5. `duty_max` changed 15→5 while RISE is at `duty`=8. Required: next upd gives `duty`=5 and `phase`=1. Then set `duty_min`=`duty_max`=9. Required: `duty` settles to 9 with no wrap or underflow.
6. Saturation. Setup: N=8, DUTY_STEP=200, `duty_min`=0, `duty_max`=255. Required: `duty` goes 0→200→255 (clamped), then 55→0.
